// File: rtl/dcache_direct_if.sv
// Bus bundle for dcache_direct: CPU data-memory port plus the block-wide
// memory port. The cache uses the slave modport; the CPU/memory side uses master.
interface dcache_direct_if;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  modport master (
    output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

  modport slave (
    input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
    output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );
endinterface

// File: rtl/dcache_direct.sv
// dcache_direct: direct-mapped, write-back, write-allocate byte data cache.
// 8 blocks x 4 bytes, address = tag[7:5] | index[4:2] | offset[1:0].
// A miss writes back a dirty victim, fetches the new block, installs it and
// lets the held request complete as a hit in IDLE.
// Optional feature macro: DCACHE_STATS_EN adds saturating HIT_COUNT/MISS_COUNT.
module dcache_direct (
  input  logic CLK,
  input  logic RESET,
  dcache_direct_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] HIT_COUNT,
  output logic [15:0] MISS_COUNT
`endif
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

  state_t      state_q, state_d;
  logic [31:0] data_arr [8];
  logic [2:0]  tag_arr  [8];
  logic [7:0]  valid_q;
  logic [7:0]  dirty_q;
  logic [31:0] fill_q;
  logic [7:0]  readdata_q;

  logic [2:0]  tag;
  logic [2:0]  idx;
  logic [1:0]  off;
  logic        req;
  logic        hit;
  logic        victim_dirty;
  logic        idle_hit;
  logic        rd_hit;
  logic        wr_hit;
  logic        idle_miss;
  logic [7:0]  sel_byte;

  logic        busywait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [7:0]  readdata;

  assign tag          = bus.ADDRESS[7:5];
  assign idx          = bus.ADDRESS[4:2];
  assign off          = bus.ADDRESS[1:0];
  assign req          = bus.READ | bus.WRITE;
  assign hit          = valid_q[idx] && (tag_arr[idx] == tag);
  assign victim_dirty = valid_q[idx] & dirty_q[idx];
  assign sel_byte     = 8'(data_arr[idx] >> {off, 3'b000});
  assign idle_hit     = (state_q == IDLE) && req && hit;
  assign idle_miss    = (state_q == IDLE) && req && !hit;
  // READ wins over an illegal simultaneous WRITE
  assign rd_hit       = idle_hit && bus.READ;
  assign wr_hit       = idle_hit && bus.WRITE && !bus.READ;

  // Next state and all bus outputs; outputs are forced idle while reset is held
  always_comb begin
    state_d       = state_q;
    busywait      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    readdata      = readdata_q;
    if (RESET) begin
      case (state_q)
        IDLE: begin
          if (req) begin
            if (hit) begin
              if (bus.READ) readdata = sel_byte;
            end else begin
              busywait = 1'b1;
              state_d  = victim_dirty ? WRITEBACK : FETCH;
            end
          end
        end
        WRITEBACK: begin
          busywait      = 1'b1;
          mem_write     = 1'b1;
          mem_address   = {tag_arr[idx], idx};
          mem_writedata = data_arr[idx];
          if (!bus.MEM_BUSYWAIT) state_d = FETCH;
        end
        FETCH: begin
          busywait    = 1'b1;
          mem_read    = 1'b1;
          mem_address = bus.ADDRESS[7:2];
          if (!bus.MEM_BUSYWAIT) state_d = UPDATE;
        end
        UPDATE: begin
          busywait = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.BUSYWAIT      = busywait;
  assign bus.MEM_READ      = mem_read;
  assign bus.MEM_WRITE     = mem_write;
  assign bus.MEM_ADDRESS   = mem_address;
  assign bus.MEM_WRITEDATA = mem_writedata;
  assign bus.READDATA      = readdata;

  // Control state: FSM, valid/dirty bits and the held read byte
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      readdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == UPDATE) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
      if (wr_hit) dirty_q[idx] <= 1'b1;
      if (rd_hit) readdata_q <= sel_byte;
    end
  end

  // Data and tag storage: fill capture, block install and byte writes (not reset)
  always_ff @(posedge CLK) begin
    if (state_q == FETCH && !bus.MEM_BUSYWAIT) fill_q <= bus.MEM_READDATA;
    if (state_q == UPDATE) begin
      data_arr[idx] <= fill_q;
      tag_arr[idx]  <= tag;
    end
    if (wr_hit) data_arr[idx][{off, 3'b000} +: 8] <= bus.WRITEDATA;
  end

`ifdef DCACHE_STATS_EN
  // Saturating hit/miss counters
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      HIT_COUNT  <= '0;
      MISS_COUNT <= '0;
    end else begin
      if (idle_hit && HIT_COUNT != 16'hFFFF)   HIT_COUNT  <= HIT_COUNT + 16'd1;
      if (idle_miss && MISS_COUNT != 16'hFFFF) MISS_COUNT <= MISS_COUNT + 16'd1;
    end
  end
`endif

endmodule
